mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single 64-bit memory bus (HADDR/HWDATA/HWRITE/HTRANS/HRDATA) between
//  the instruction-fetch requester (IF) and the memory-access stage (MEM).
//  Sequences each transfer as address phase then data phase, honouring HREADY wait states.
//  Fixed priority MEM > IF with a starvation guard for IF. Sits between the pipeline
//  and the memory model; sub-word load extension and store byte merge stay in the MEM stage.
// PARAMETERS
//  AW          64  address width
//  DW          64  data width
//  STARVE_MAX  4   consecutive MEM grants allowed while if_req is pending (>=1)
// PORTS
//  CLK        in   1   single clock, all state updates on posedge
//  RST_N      in   1   asynchronous active-low reset
//  if_req     in   1   IF read request; hold with if_addr stable until if_gnt
//  if_addr    in   AW  IF read address
//  if_gnt     out  1   1-cycle pulse: IF request accepted (address phase this cycle)
//  if_done    out  1   1-cycle pulse: if_rdata valid
//  if_rdata   out  DW  captured HRDATA for IF
//  mem_req    in   1   MEM request; hold with mem_addr/mem_write/mem_wdata until mem_gnt
//  mem_addr   in   AW  MEM address
//  mem_write  in   1   1 = store, 0 = load
//  mem_wdata  in   DW  store data (already byte-merged)
//  mem_gnt    out  1   1-cycle pulse: MEM request accepted
//  mem_done   out  1   1-cycle pulse: transfer complete; mem_rdata valid for loads
//  mem_rdata  out  DW  captured HRDATA for MEM (0 after stores)
//  HADDR      out  AW  bus address, valid while HTRANS=1
//  HWRITE     out  1   bus direction, valid while HTRANS=1
//  HTRANS     out  1   1 = address phase of a transfer this cycle
//  HWDATA     out  DW  store data, driven during data phase
//  HRDATA     in   DW  read data, sampled in data phase when HREADY=1
//  HREADY     in   1   data phase completes this cycle when 1
// BEHAVIOUR
//  Reset (async, RST_N=0): state=IDLE, owner=none, starve_cnt=0; every output 0.
//  Reset mid-transfer aborts it silently: no done pulse; requesters reissue.
//  States: IDLE -> ADDR -> DATA -> (IDLE | ADDR). One transfer outstanding at most.
//  IDLE: winner = MEM if mem_req and !(if_req && starve_cnt==STARVE_MAX), else IF if if_req.
//   On winner: register HADDR/HWRITE (IF: HWRITE=0), latch wdata; next cycle state=ADDR,
//   HTRANS=1, winner's gnt=1 (both registered, same cycle). No req: stay IDLE.
//  ADDR: exactly one cycle; HTRANS->0, HWDATA=latched wdata (writes), next state DATA.
//  DATA: HREADY=0 -> stay, HWDATA held. HREADY=1 -> owner's done=1 next cycle with
//   rdata=HRDATA (reads) or 0 (stores); same edge re-arbitrates as IDLE does, so a
//   pending request enters ADDR directly (back-to-back, no idle bubble); else IDLE.
//  Minimum latency: req high in cycle 0 -> gnt+HTRANS cycle 1 -> DATA cycle 2 ->
//   done cycle 3 (HREADY=1). Each HREADY=0 cycle adds one.
//  Owner's req is ignored from gnt until done; req high in or after the done cycle
//   is a new request. The other requester may hold req throughout; it waits.
//  starve_cnt: +1 (saturating at STARVE_MAX) on each MEM grant while if_req=1;
//   cleared on IF grant or whenever if_req=0 at an arbitration point.
//  Simultaneous req with starve_cnt<STARVE_MAX: MEM wins. At STARVE_MAX: IF wins.
//  if_rdata/mem_rdata hold last value between done pulses. Addresses pass through
//   unmodified (no alignment check). No timeout: HREADY stuck 0 holds DATA forever.
// TESTING
//  1 Reset: RST_N=0 mid-DATA -> all outputs 0 at once, no done; reissue completes normally.
//  2 Lone IF read addr 0x1000, HREADY=1, HRDATA=0xDEAD -> gnt c1, HTRANS c1 only,
//    if_done c3 with if_rdata=0xDEAD.
//  3 MEM store addr 0x2008 wdata 0x55, HREADY low 2 cycles -> HWRITE=1 in ADDR,
//    HWDATA=0x55 through DATA, mem_done 2 cycles later than case 2, mem_rdata=0.
//  4 if_req and mem_req same cycle -> mem_gnt first; if_gnt in cycle of mem_done
//    (back-to-back, HTRANS=1 that cycle), if_done 2 cycles later.
//  5 mem_req held continuously, if_req held, STARVE_MAX=4 -> 4 MEM grants then 1 IF
//    grant, pattern repeats; IF never waits more than 4 transfers.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-requester (IF/MEM) arbiter sequencing address/data phases on one memory bus
module mem_bus_arbiter #(
    parameter int AW         = 64,
    parameter int DW         = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          mem_req,
    input  logic [AW-1:0] mem_addr,
    input  logic          mem_write,
    input  logic [DW-1:0] mem_wdata,
    output logic          mem_gnt,
    output logic          mem_done,
    output logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] HADDR,
    output logic          HWRITE,
    output logic          HTRANS,
    output logic [DW-1:0] HWDATA,
    input  logic [DW-1:0] HRDATA,
    input  logic          HREADY
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state;
    logic          owner_mem;
    logic [DW-1:0] wdata_q;
    logic [CW-1:0] starve_cnt;

    logic starved;
    logic pick_mem;
    logic pick_if;
    logic arb_point;

    // Arbitration: MEM has priority unless IF has already waited STARVE_MAX MEM grants.
    // Arbitration happens in IDLE and on the completing DATA cycle, which gives back-to-back transfers.
    always_comb begin
        starved   = if_req && (starve_cnt == CW'(STARVE_MAX));
        pick_mem  = mem_req && !starved;
        pick_if   = if_req && !pick_mem;
        arb_point = (state == IDLE) || ((state == DATA) && HREADY);
    end

    // Bus sequencer: phase state, registered bus signals, grant/done pulses and starvation counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            owner_mem  <= 1'b0;
            wdata_q    <= '0;
            starve_cnt <= '0;
            if_gnt     <= 1'b0;
            if_done    <= 1'b0;
            if_rdata   <= '0;
            mem_gnt    <= 1'b0;
            mem_done   <= 1'b0;
            mem_rdata  <= '0;
            HADDR      <= '0;
            HWRITE     <= 1'b0;
            HTRANS     <= 1'b0;
            HWDATA     <= '0;
        end else begin
            if_gnt   <= 1'b0;
            mem_gnt  <= 1'b0;
            if_done  <= 1'b0;
            mem_done <= 1'b0;

            case (state)
                ADDR: begin
                    HTRANS <= 1'b0;
                    HWDATA <= HWRITE ? wdata_q : '0;
                    state  <= DATA;
                end
                DATA: begin
                    if (HREADY) begin
                        HWDATA <= '0;
                        state  <= IDLE;
                        if (owner_mem) begin
                            mem_done  <= 1'b1;
                            mem_rdata <= HWRITE ? '0 : HRDATA;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= HRDATA;
                        end
                    end
                end
                default: ;
            endcase

            // A winner here overrides the IDLE fall-back chosen above for a completing DATA.
            if (arb_point) begin
                if (pick_mem) begin
                    state     <= ADDR;
                    HTRANS    <= 1'b1;
                    mem_gnt   <= 1'b1;
                    owner_mem <= 1'b1;
                    HADDR     <= mem_addr;
                    HWRITE    <= mem_write;
                    wdata_q   <= mem_wdata;
                    if (!if_req) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != CW'(STARVE_MAX)) begin
                        starve_cnt <= starve_cnt + CW'(1);
                    end
                end else if (pick_if) begin
                    state      <= ADDR;
                    HTRANS     <= 1'b1;
                    if_gnt     <= 1'b1;
                    owner_mem  <= 1'b0;
                    HADDR      <= if_addr;
                    HWRITE     <= 1'b0;
                    wdata_q    <= '0;
                    starve_cnt <= '0;
                end else begin
                    starve_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_done;
    logic [63:0] if_rdata;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_write;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_done;
    logic [63:0] mem_rdata;
    logic [63:0] HADDR;
    logic        HWRITE;
    logic        HTRANS;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HREADY;

    always #5 CLK = ~CLK;

    mem_bus_arbiter #(.AW(64), .DW(64), .STARVE_MAX(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY)
    );

    typedef struct {
        bit          is_mem;
        bit          wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] hrdata;
        int          waits;
        int          exp_lat;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_if_q[$];
    logic [63:0] exp_mem_q[$];
    logic [63:0] e_if;
    logic [63:0] e_mem;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse consumes the oldest expected read data for that requester.
    always @(negedge CLK) begin
        if (if_done) begin
            if (exp_if_q.size() == 0) begin
                chk("if_done_unexpected", 64'(if_done), 64'd0);
            end else begin
                e_if = exp_if_q.pop_front();
                chk("if_rdata", if_rdata, e_if);
            end
        end
        if (mem_done) begin
            if (exp_mem_q.size() == 0) begin
                chk("mem_done_unexpected", 64'(mem_done), 64'd0);
            end else begin
                e_mem = exp_mem_q.pop_front();
                chk("mem_rdata", mem_rdata, e_mem);
            end
        end
    end

    task automatic run_single(input vec_t v, input string tag);
        int c;
        int done_c;
        bit saw_if;
        bit saw_mem;
        saw_if    = 1'b0;
        saw_mem   = 1'b0;
        if_req    = !v.is_mem;
        mem_req   = v.is_mem;
        if_addr   = v.addr;
        mem_addr  = v.addr;
        mem_write = v.wr;
        mem_wdata = v.wdata;
        HRDATA    = v.hrdata;
        HREADY    = 1'b1;
        if (v.is_mem) exp_mem_q.push_back(v.exp_rdata);
        else          exp_if_q.push_back(v.exp_rdata);
        @(negedge CLK);
        chk({tag, "_gnt"}, 64'({if_gnt, mem_gnt}), v.is_mem ? 64'd1 : 64'd2);
        chk({tag, "_htrans_addr"}, 64'(HTRANS), 64'd1);
        chk({tag, "_haddr"}, HADDR, v.addr);
        chk({tag, "_hwrite"}, 64'(HWRITE), 64'(v.wr));
        if_req  = 1'b0;
        mem_req = 1'b0;
        @(negedge CLK);
        chk({tag, "_htrans_data"}, 64'(HTRANS), 64'd0);
        c      = 2;
        done_c = -1;
        while (c < 40) begin
            if (if_done || mem_done) begin
                done_c  = c;
                saw_if  = if_done;
                saw_mem = mem_done;
                break;
            end
            if (v.wr) chk({tag, "_hwdata"}, HWDATA, v.wdata);
            HREADY = (c - 2 >= v.waits);
            @(negedge CLK);
            c++;
        end
        chk({tag, "_latency"}, 64'(done_c), 64'(v.exp_lat));
        chk({tag, "_done_owner"}, 64'({saw_if, saw_mem}), v.is_mem ? 64'd1 : 64'd2);
        chk({tag, "_htrans_after"}, 64'(HTRANS), 64'd0);
        @(negedge CLK);
        chk({tag, "_rdata_hold"}, v.is_mem ? mem_rdata : if_rdata, v.exp_rdata);
    endtask

    logic any_out;
    bit   pat[10];
    int   cnt_model;
    int   ng;
    int   cyc;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 64'h1000, 64'h0, 64'hDEAD, 0, 3, 64'hDEAD};
        vecs[1] = '{1'b1, 1'b1, 64'h2008, 64'h55, 64'h1234, 2, 5, 64'h0};
        vecs[2] = '{1'b1, 1'b0, 64'h3000, 64'h0, 64'hA5A5_0000_FFFF_0001, 1, 4, 64'hA5A5_0000_FFFF_0001};
        vecs[3] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{1'b1, 1'b1, 64'h7, 64'hFFFF_0000_1234_5678, 64'hBEEF, 3, 6, 64'h0};
        vecs[5] = '{1'b0, 1'b0, 64'h0, 64'h0, 64'h0BAD_F00D, 1, 4, 64'h0BAD_F00D};

        RST_N = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_addr = '0;
        mem_write = 1'b0; mem_wdata = '0; HRDATA = '0; HREADY = 1'b1;
        repeat (3) @(negedge CLK);
        any_out = |{if_gnt, if_done, if_rdata, mem_gnt, mem_done, mem_rdata, HADDR, HWRITE, HTRANS, HWDATA};
        chk("reset_state", 64'(any_out), 64'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 6; i++) run_single(vecs[i], $sformatf("vec%0d", i));

        // Reset while a store sits in a stalled data phase.
        mem_req = 1'b1; mem_addr = 64'h4000; mem_write = 1'b1; mem_wdata = 64'h77; HREADY = 1'b0;
        @(negedge CLK);
        mem_req = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_pre_hwdata", HWDATA, 64'h77);
        #2 RST_N = 1'b0;
        #1;
        any_out = |{if_gnt, if_done, if_rdata, mem_gnt, mem_done, mem_rdata, HADDR, HWRITE, HTRANS, HWDATA};
        chk("reset_mid_data", 64'(any_out), 64'd0);
        @(negedge CLK);
        HREADY = 1'b1;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        chk("rst_idle_htrans", 64'(HTRANS), 64'd0);
        run_single(vecs[1], "reissue");

        // Simultaneous requests: MEM first, IF granted back-to-back in the MEM done cycle.
        if_req = 1'b1; if_addr = 64'h5000; mem_req = 1'b1; mem_addr = 64'h6000; mem_write = 1'b0;
        HRDATA = 64'h1111; HREADY = 1'b1;
        exp_mem_q.push_back(64'h1111);
        exp_if_q.push_back(64'h2222);
        @(negedge CLK);
        chk("sim_c1_gnt", 64'({if_gnt, mem_gnt}), 64'd1);
        chk("sim_c1_haddr", HADDR, 64'h6000);
        mem_req = 1'b0;
        @(negedge CLK);
        chk("sim_c2_htrans", 64'(HTRANS), 64'd0);
        @(negedge CLK);
        chk("sim_c3_done_gnt", 64'({mem_done, if_gnt, HTRANS}), 64'd7);
        chk("sim_c3_haddr", HADDR, 64'h5000);
        if_req = 1'b0;
        HRDATA = 64'h2222;
        @(negedge CLK);
        chk("sim_c4_if_done", 64'(if_done), 64'd0);
        @(negedge CLK);
        chk("sim_c5_if_done", 64'(if_done), 64'd1);
        repeat (2) @(negedge CLK);

        // Starvation guard with both requests held.
        cnt_model = 0;
        for (int k = 0; k < 10; k++) begin
            if (cnt_model == 4) begin pat[k] = 1'b1; cnt_model = 0; end
            else begin pat[k] = 1'b0; cnt_model++; end
            if (pat[k]) exp_if_q.push_back(64'hC0FFEE);
            else        exp_mem_q.push_back(64'hC0FFEE);
        end
        mem_req = 1'b1; mem_addr = 64'h8000; mem_write = 1'b0; if_req = 1'b1; if_addr = 64'h9000;
        HRDATA = 64'hC0FFEE; HREADY = 1'b1;
        ng  = 0;
        cyc = 0;
        while (ng < 10 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            if (if_gnt || mem_gnt) begin
                chk($sformatf("grant_order%0d", ng), 64'({if_gnt, mem_gnt}), pat[ng] ? 64'd2 : 64'd1);
                ng++;
                if (ng == 10) begin
                    if_req  = 1'b0;
                    mem_req = 1'b0;
                end
            end
        end
        chk("starve_grants_seen", 64'(ng), 64'd10);
        if_req = 1'b0; mem_req = 1'b0;
        repeat (6) @(negedge CLK);

        chk("sb_if_left", 64'(exp_if_q.size()), 64'd0);
        chk("sb_mem_left", 64'(exp_mem_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
